// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 key schedule.
// Used by aes_key_schedule_seq and its Keygeneration round-step module.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int NUM_RK     = NUM_ROUNDS + 1;
    localparam int KEY_W      = 128;

    typedef logic [3:0] rk_idx_t;

    localparam rk_idx_t LAST_RK = 4'd10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as the multiplicative inverse (x^254, so 0 maps to 0)
    // followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input rk_idx_t cnt);
        logic [7:0] r;
        case (cnt)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// Key-load handshake and round-key read port of aes_key_schedule_seq.
// Handshake: a key transfers on a rising edge where key_in_valid and key_in_ready are both 1.
interface aes_key_schedule_seq_if;
    import aes_pkg::*;

    logic [KEY_W-1:0] key_in;
    logic             key_in_valid;
    logic             key_in_ready;
    rk_idx_t          rk_idx;
    logic [KEY_W-1:0] rk_data;
    logic             keys_valid;
    logic             busy;
    state_t           dbg_state;

    modport master (
        output key_in, key_in_valid, rk_idx,
        input  key_in_ready, rk_data, keys_valid, busy, dbg_state
    );

    modport slave (
        input  key_in, key_in_valid, rk_idx,
        output key_in_ready, rk_data, keys_valid, busy, dbg_state
    );

endinterface

// File: rtl/aes_key_schedule_seq_keygeneration.sv
// Keygeneration: combinational single-round AES-128 key expansion step.
// count selects the round constant; key is the previous round key.
module Keygeneration
    import aes_pkg::*;
(
    input  rk_idx_t          count,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] keyoutput
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, temp;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0   = key[127:96];
        w1   = key[95:64];
        w2   = key[63:32];
        w3   = key[31:0];
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon(count), 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        keyoutput = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128 key schedule: one expansion round per clock into an 11-entry key file.
// Optional macro KEYSCHED_ZEROIZE_EN adds a zeroize input that wipes all stored keys.
module aes_key_schedule_seq
    import aes_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic zeroize,
`endif
    aes_key_schedule_seq_if.slave ks
);

    state_t           state;
    rk_idx_t          cnt;
    logic [KEY_W-1:0] rk [NUM_RK];
    logic [KEY_W-1:0] next_rk;
    logic             keys_valid_q;
    logic             busy_q;
    logic             ready_q;
    logic             clear;

`ifdef KEYSCHED_ZEROIZE_EN
    assign clear           = rst | zeroize;
    assign ks.key_in_ready = ready_q & ~zeroize;
`else
    assign clear           = rst;
    assign ks.key_in_ready = ready_q;
`endif

    Keygeneration u_keygen (
        .count     (cnt),
        .key       (rk[cnt]),
        .keyoutput (next_rk)
    );

    // Zeroize and reset produce the same post-clear state; rst still has priority
    // over accept because clear is checked first.
    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= IDLE;
            cnt          <= '0;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
            for (int i = 0; i < NUM_RK; i++) rk[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (ks.key_in_valid) begin
                        rk[0]        <= ks.key_in;
                        cnt          <= '0;
                        state        <= EXPAND;
                        keys_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        ready_q      <= 1'b0;
                    end
                end
                EXPAND: begin
                    rk[cnt + 4'd1] <= next_rk;
                    cnt            <= cnt + 4'd1;
                    if (cnt == LAST_RK - 4'd1) begin
                        state        <= DONE;
                        keys_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        ready_q      <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ks.rk_data    = (ks.rk_idx <= LAST_RK) ? rk[ks.rk_idx] : '0;
    assign ks.keys_valid = keys_valid_q;
    assign ks.busy       = busy_q;
    assign ks.dbg_state  = state;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed self-checking bench for aes_key_schedule_seq using FIPS-197 and all-zero key vectors.
// Zeroize checks are compiled in when KEYSCHED_ZEROIZE_EN is defined.
module tb_aes_key_schedule_seq;
    import aes_pkg::*;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic zeroize = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    aes_key_schedule_seq_if kif ();

    aes_key_schedule_seq dut (
        .clk     (clk),
        .rst     (rst),
`ifdef KEYSCHED_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .ks      (kif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input logic [3:0] idx, input string tag, input logic [127:0] exp);
        kif.rk_idx = idx;
        #1;
        check(tag, kif.rk_data, exp);
    endtask

    // Accept edge happens in the first step; then 10 more edges to DONE.
    // While expanding, alt_key is presented with valid high to prove it is ignored.
    task automatic load_key(input logic [127:0] key, input logic [127:0] alt_key, input string tag);
        kif.key_in       = key;
        kif.key_in_valid = 1'b1;
        step();
        check({tag, "_accept_kv"}, 128'(kif.keys_valid), 128'(0));
        check({tag, "_accept_busy"}, 128'(kif.busy), 128'(1));
        kif.key_in = alt_key;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 10) kif.key_in_valid = 1'b0;
            check($sformatf("%s_kv_c%0d", tag, i), 128'(kif.keys_valid), 128'(i == 10));
            check($sformatf("%s_rdy_c%0d", tag, i), 128'(kif.key_in_ready), 128'(i == 10));
        end
        check({tag, "_state_done"}, 128'(kif.dbg_state), 128'(DONE));
    endtask

    initial begin
        kif.key_in       = '0;
        kif.key_in_valid = 1'b0;
        kif.rk_idx       = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_kv", 128'(kif.keys_valid), 128'(0));
        check("rst_busy", 128'(kif.busy), 128'(0));
        check("rst_ready", 128'(kif.key_in_ready), 128'(1));
        check("rst_state", 128'(kif.dbg_state), 128'(IDLE));
        read_rk(4'd0, "rst_rk0", 128'h0);

        // FIPS key with a conflicting zero key held valid during expansion.
        load_key(FIPS_KEY, 128'h0, "fips");
        read_rk(4'd0, "fips_rk0", FIPS_KEY);
        read_rk(4'd1, "fips_rk1", FIPS_RK1);
        read_rk(4'd10, "fips_rk10", FIPS_RK10);
        read_rk(4'd11, "fips_rk11", 128'h0);
        read_rk(4'd12, "fips_rk12", 128'h0);

        // Reload from DONE with the zero key.
        load_key(128'h0, FIPS_KEY, "zero");
        read_rk(4'd0, "zero_rk0", 128'h0);
        read_rk(4'd1, "zero_rk1", ZERO_RK1);
        read_rk(4'd10, "zero_rk10", ZERO_RK10);
        read_rk(4'd15, "zero_rk15", 128'h0);

        // Reset partway through expansion.
        kif.key_in       = FIPS_KEY;
        kif.key_in_valid = 1'b1;
        step();
        kif.key_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_busy", 128'(kif.busy), 128'(1));
        rst = 1'b1;
        kif.key_in_valid = 1'b1;
        step();
        rst = 1'b0;
        kif.key_in_valid = 1'b0;
        check("abort_kv", 128'(kif.keys_valid), 128'(0));
        check("abort_busy", 128'(kif.busy), 128'(0));
        check("abort_ready", 128'(kif.key_in_ready), 128'(1));
        check("abort_state", 128'(kif.dbg_state), 128'(IDLE));
        for (int i = 0; i <= 10; i++)
            read_rk(4'(i), $sformatf("abort_rk%0d", i), 128'h0);

        load_key(FIPS_KEY, 128'h0, "reload");
        read_rk(4'd1, "reload_rk1", FIPS_RK1);
        read_rk(4'd10, "reload_rk10", FIPS_RK10);

`ifdef KEYSCHED_ZEROIZE_EN
        zeroize = 1'b1;
        kif.key_in = 128'h0;
        kif.key_in_valid = 1'b1;
        #1;
        check("zz_ready_low", 128'(kif.key_in_ready), 128'(0));
        step();
        zeroize = 1'b0;
        kif.key_in_valid = 1'b0;
        check("zz_kv", 128'(kif.keys_valid), 128'(0));
        check("zz_busy", 128'(kif.busy), 128'(0));
        check("zz_state", 128'(kif.dbg_state), 128'(IDLE));
        for (int i = 0; i <= 10; i++)
            read_rk(4'(i), $sformatf("zz_rk%0d", i), 128'h0);
        step();
        check("zz_no_accept_state", 128'(kif.dbg_state), 128'(IDLE));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
